equiv_check_sequencer: RTL and testbench
========================================

Name: equiv_check_sequencer

Overview:
- Synthesizable sequencer for golden-vs-post-route equivalence runs.
- Applies a reset phase with zero stimulus, releases reset, then drives NUM_VECTORS pseudo-random stimulus words from an internal LFSR.
- Compares the golden and netlist output buses SETTLE_CYCLES after each stimulus change, and reports mismatch count and first-failure data.
- Sits between the stimulus source and both DUT copies, and owns their shared reset and input bus.

Parameters:
DATA_W, 32, width of the stimulus and compared output buses
NUM_VECTORS, 1000, number of random vectors after the reset check
RESET_CYCLES, 2, cycles dut_rst is held high with stim=0
SETTLE_CYCLES, 2, cycles from a stimulus change to its compare (min 1)
LFSR_SEED, 32'hACE12468, initial LFSR state; a value of 0 is replaced by 1

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-low reset
start  in  1  single-cycle run request; ignored while busy
dut_rst  out  1  active-high reset driven to both DUT copies
stim  out  DATA_W  stimulus bus driven to both DUT copies
golden_out  in  DATA_W  golden model output
netlist_out  in  DATA_W  post-route netlist output
busy  out  1  run in progress
done  out  1  run finished; held until next start or reset
pass  out  1  valid while done; 1 when mismatch_cnt==0
mismatch_cnt  out  16  number of mismatches; saturates at 16'hFFFF
vec_cnt  out  16  number of random vectors compared so far
err_pulse  out  1  one-cycle pulse on each mismatching compare
fail_idx  out  16  vec_cnt value at first mismatch; 0 denotes the reset check
fail_golden  out  DATA_W  golden_out captured at first mismatch
fail_netlist  out  DATA_W  netlist_out captured at first mismatch

Behaviour:
- Reset (rst==0 on a clock edge):
  - State IDLE; dut_rst=1; stim=0.
  - busy, done, pass, err_pulse, mismatch_cnt, vec_cnt, fail_* all 0.
  - LFSR loaded with LFSR_SEED.
  - Reset mid-run aborts immediately; no partial results are kept.
- LFSR: 32-bit Galois, taps 32'h80200003. Shift: lsb=1 -> next = (s>>1)^taps, else next = s>>1. stim takes the low DATA_W bits.
- FSM states and transitions:
  - IDLE: dut_rst=1, stim=0. start -> RST_HOLD; clear counters and fail_*, reload LFSR, busy=1.
  - RST_HOLD: dut_rst=1, stim=0 for RESET_CYCLES cycles. In the final cycle, compare golden_out vs netlist_out (reset check, index 0), then -> RELEASE.
  - RELEASE: dut_rst=0 for 1 cycle. If NUM_VECTORS==0 -> DONE, else -> DRIVE.
  - DRIVE: 1 cycle. stim <= LFSR; LFSR advances -> SETTLE.
  - SETTLE: stim held. Compare on the SETTLE_CYCLES-th cycle after stim was registered. vec_cnt increments on every compare. If vec_cnt reaches NUM_VECTORS -> DONE, else -> DRIVE.
  - DONE: busy=0, done=1, pass=(mismatch_cnt==0), dut_rst=0, stim holds its last value. start -> RST_HOLD as a fresh run.
- Vector period is 1+SETTLE_CYCLES cycles; with defaults, stim changes every 3 cycles.
- Compare: full-width inequality. On mismatch:
  - err_pulse=1 in the following cycle.
  - mismatch_cnt increments (saturating).
  - fail_idx/fail_golden/fail_netlist are captured only when mismatch_cnt was 0 (first mismatch only).
- start asserted while busy is ignored. start in the same cycle as rst==0 is ignored (reset wins).

Optional Feature:
- MISMATCH_STOP_EN defined:
  - The first mismatch forces a transition to DONE on the next cycle, with pass=0.
  - stim and vec_cnt are frozen at the failing vector; mismatch_cnt ends at 1.
- Not defined: the run always completes all NUM_VECTORS and counts every mismatch.

Test Plan:
- Identical DUT stubs (out=stim), defaults, start pulse:
  - dut_rst high 2 cycles, then low.
  - 1000 compares; done=1, pass=1, mismatch_cnt=0, vec_cnt=1000.
  - stim changes every 3 cycles.
- Netlist stub forces bit 5 of vector 7 wrong -> err_pulse once; mismatch_cnt=1, fail_idx=7, fail_golden^fail_netlist=32'h20, pass=0.
- Netlist stub outputs 32'h1 during reset -> reset check fails; fail_idx=0, mismatch_cnt counts the reset check plus the vector mismatches.
- rst low at vector 500, then start -> counters restart from 0; stim sequence is identical to the first run (seed reload).
- NUM_VECTORS=0 -> DONE 1 cycle after RELEASE; vec_cnt=0, pass reflects the reset check only.
- MISMATCH_STOP_EN with a mismatch at vector 3 -> DONE one cycle after the compare; vec_cnt=3, mismatch_cnt=1, stim frozen at vector 3's value.

Source files
------------

// File: rtl/equiv_check_sequencer.sv
// Golden-vs-netlist equivalence sequencer: reset check, then LFSR vectors compared after a settle delay.
// Optional feature macro: MISMATCH_STOP_EN ends the run at the first mismatch.
module equiv_check_sequencer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_VECTORS   = 1000,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED     = 32'hACE12468
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              dut_rst,
  output logic [DATA_W-1:0] stim,
  input  logic [DATA_W-1:0] golden_out,
  input  logic [DATA_W-1:0] netlist_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       mismatch_cnt,
  output logic [15:0]       vec_cnt,
  output logic              err_pulse,
  output logic [15:0]       fail_idx,
  output logic [DATA_W-1:0] fail_golden,
  output logic [DATA_W-1:0] fail_netlist
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RELEASE, S_DRIVE, S_SETTLE, S_DONE
  } state_e;

  localparam logic [31:0] TAPS        = 32'h80200003;
  localparam logic [31:0] SEED        = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [15:0] HOLD_LAST   = 16'((RESET_CYCLES > 1) ? RESET_CYCLES - 1 : 0);
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [15:0] NUM_VEC     = 16'(NUM_VECTORS);
`ifdef MISMATCH_STOP_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_e            state_q;
  logic [15:0]       phase_q;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] stim_q;
  logic              dut_rst_q, busy_q, done_q, pass_q, err_pulse_q;
  logic [15:0]       mismatch_cnt_q, mismatch_cnt_d;
  logic [15:0]       vec_cnt_q, vec_cnt_d;
  logic [15:0]       fail_idx_q;
  logic [DATA_W-1:0] fail_golden_q, fail_netlist_q;
  logic              cmp_en, miscmp, to_done;
  logic [15:0]       cmp_idx;

  // Compare strobes and next-value arithmetic shared by the FSM below.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cmp_en    = 1'b0;
    cmp_idx   = 16'd0;
    vec_cnt_d = vec_cnt_q;
    if (state_q == S_RST_HOLD && phase_q == HOLD_LAST) cmp_en = 1'b1;
    if (state_q == S_SETTLE && phase_q == SETTLE_LAST) begin
      cmp_en    = 1'b1;
      cmp_idx   = vec_cnt_q + 16'd1;
      vec_cnt_d = cmp_idx;
    end
    miscmp         = cmp_en && (golden_out != netlist_out);
    mismatch_cnt_d = (miscmp && mismatch_cnt_q != 16'hFFFF) ? mismatch_cnt_q + 16'd1
                                                             : mismatch_cnt_q;
    to_done = (state_q == S_RST_HOLD && cmp_en && STOP_ON_FAIL && miscmp)
           || (state_q == S_RELEASE && NUM_VEC == 16'd0)
           || (state_q == S_SETTLE && cmp_en
               && ((STOP_ON_FAIL && miscmp) || vec_cnt_d == NUM_VEC));
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      phase_q        <= 16'd0;
      lfsr_q         <= SEED;
      stim_q         <= '0;
      dut_rst_q      <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_pulse_q    <= 1'b0;
      mismatch_cnt_q <= 16'd0;
      vec_cnt_q      <= 16'd0;
      fail_idx_q     <= 16'd0;
      fail_golden_q  <= '0;
      fail_netlist_q <= '0;
    end else begin
      err_pulse_q    <= miscmp;
      mismatch_cnt_q <= mismatch_cnt_d;
      vec_cnt_q      <= vec_cnt_d;
      if (miscmp && mismatch_cnt_q == 16'd0) begin
        fail_idx_q     <= cmp_idx;
        fail_golden_q  <= golden_out;
        fail_netlist_q <= netlist_out;
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            // NOTE: a later non-blocking assignment to the same register wins, so these clears override the defaults above.
            state_q        <= S_RST_HOLD;
            phase_q        <= 16'd0;
            lfsr_q         <= SEED;
            stim_q         <= '0;
            dut_rst_q      <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            mismatch_cnt_q <= 16'd0;
            vec_cnt_q      <= 16'd0;
            fail_idx_q     <= 16'd0;
            fail_golden_q  <= '0;
            fail_netlist_q <= '0;
          end
        end
        S_RST_HOLD: begin
          phase_q <= cmp_en ? 16'd0 : phase_q + 16'd1;
          if (cmp_en && !to_done) begin
            state_q   <= S_RELEASE;
            dut_rst_q <= 1'b0;
          end
        end
        S_RELEASE: if (!to_done) state_q <= S_DRIVE;
        S_DRIVE: begin
          stim_q  <= lfsr_q[DATA_W-1:0];
          lfsr_q  <= lfsr_d;
          phase_q <= 16'd0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          phase_q <= phase_q + 16'd1;
          if (cmp_en && !to_done) state_q <= S_DRIVE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (to_done) begin
        state_q   <= S_DONE;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        pass_q    <= (mismatch_cnt_d == 16'd0);
        dut_rst_q <= 1'b0;
      end
    end
  end

  assign dut_rst      = dut_rst_q;
  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign vec_cnt      = vec_cnt_q;
  assign err_pulse    = err_pulse_q;
  assign fail_idx     = fail_idx_q;
  assign fail_golden  = fail_golden_q;
  assign fail_netlist = fail_netlist_q;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Bench for equiv_check_sequencer: stub DUT copies with injectable faults, checked against a vector-level model.
// Expectations follow MISMATCH_STOP_EN when the bench is built with that macro.
module tb_equiv_check_sequencer;

  localparam int          R    = 2;
  localparam int          S    = 2;
  localparam int          NA   = 1000;
  localparam logic [31:0] SEED = 32'hACE12468;
`ifdef MISMATCH_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sel;
  logic        a_dut_rst, a_busy, a_done, a_pass, a_err;
  logic [31:0] a_stim, a_gold, a_net, a_fg, a_fn;
  logic [15:0] a_mm, a_vc, a_fi;
  logic        b_dut_rst, b_busy, b_done, b_pass, b_err;
  logic [31:0] b_stim, b_gold, b_net, b_fg, b_fn;
  logic [15:0] b_mm, b_vc, b_fi;

  int          f_idx  [4];
  logic [31:0] f_mask [4];
  logic [31:0] f_val  [4];
  logic [31:0] rst_net_val;
  logic [31:0] vseq [0:NA];

  int n_vectors = 0;
  int n_miscompares = 0;

  equiv_check_sequencer #(.DATA_W(32), .NUM_VECTORS(NA), .RESET_CYCLES(R),
                          .SETTLE_CYCLES(S), .LFSR_SEED(SEED)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_rst(a_dut_rst), .stim(a_stim),
    .golden_out(a_gold), .netlist_out(a_net), .busy(a_busy), .done(a_done),
    .pass(a_pass), .mismatch_cnt(a_mm), .vec_cnt(a_vc), .err_pulse(a_err),
    .fail_idx(a_fi), .fail_golden(a_fg), .fail_netlist(a_fn));

  equiv_check_sequencer #(.DATA_W(32), .NUM_VECTORS(0), .RESET_CYCLES(R),
                          .SETTLE_CYCLES(S), .LFSR_SEED(SEED)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_rst(b_dut_rst), .stim(b_stim),
    .golden_out(b_gold), .netlist_out(b_net), .busy(b_busy), .done(b_done),
    .pass(b_pass), .mismatch_cnt(b_mm), .vec_cnt(b_vc), .err_pulse(b_err),
    .fail_idx(b_fi), .fail_golden(b_fg), .fail_netlist(b_fn));

  // Golden stubs follow stim (0 in reset); netlist stubs add the configured faults.
  assign a_gold = a_dut_rst ? 32'd0 : a_stim;
  assign b_gold = b_dut_rst ? 32'd0 : b_stim;
  assign b_net  = b_dut_rst ? rst_net_val : b_stim;
  always_comb begin
    a_net = a_stim;
    if (a_dut_rst) a_net = rst_net_val;
    else
      for (int i = 0; i < 4; i++)
        if (f_mask[i] != 32'd0 && a_stim == f_val[i]) a_net = a_stim ^ f_mask[i];
  end

  logic        o_dut_rst, o_busy, o_done, o_pass, o_err;
  logic [31:0] o_stim, o_fg, o_fn;
  logic [15:0] o_mm, o_vc, o_fi;
  assign o_dut_rst = sel ? b_dut_rst : a_dut_rst;
  assign o_busy    = sel ? b_busy    : a_busy;
  assign o_done    = sel ? b_done    : a_done;
  assign o_pass    = sel ? b_pass    : a_pass;
  assign o_err     = sel ? b_err     : a_err;
  assign o_stim    = sel ? b_stim    : a_stim;
  assign o_fg      = sel ? b_fg      : a_fg;
  assign o_fn      = sel ? b_fn      : a_fn;
  assign o_mm      = sel ? b_mm      : a_mm;
  assign o_vc      = sel ? b_vc      : a_vc;
  assign o_fi      = sel ? b_fi      : a_fi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic clear_faults();
    rst_net_val = 32'd0;
    for (int i = 0; i < 4; i++) begin
      f_idx[i] = 1; f_mask[i] = 32'd0; f_val[i] = 32'd0;
    end
  endtask

  task automatic set_fault(input int slot, input int idx, input logic [31:0] mask);
    f_idx[slot] = idx; f_mask[slot] = mask; f_val[slot] = vseq[idx];
  endtask

  task automatic random_faults(input int nf, input bit rst_bad);
    clear_faults();
    rst_net_val = rst_bad ? ($urandom() | 32'h1) : 32'd0;
    for (int i = 0; i < nf; i++) begin
      int idx;
      bit dup;
      do begin
        idx = $urandom_range(NA, 1);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (f_idx[j] == idx) dup = 1'b1;
      end while (dup);
      set_fault(i, idx, $urandom() | (32'h1 << $urandom_range(31, 0)));
    end
  endtask

  task automatic drive_start(input bit v);
    start_a = v && !sel;
    start_b = v && sel;
  endtask

  // One full run: model expectations from the fault set, then observe the run cycle by cycle.
  task automatic run_check(input string tag, input bit use_b);
    int nvec, first, nhit, applied, exp_mm, lat, n, k, seq_bad, rst_hi, pulse_bad;
    logic [31:0] first_mask, exp_fg, exp_fn, exp_stim, prev;
    logic [15:0] exp_fidx;
    int exp_pulse[$];
    int got_pulse[$];
    bit rst_fail, timed_out, found;
    sel = use_b;
    nvec = use_b ? 0 : NA;
    first = 0; nhit = 0; first_mask = 32'd0;
    for (int i = 0; i < 4; i++)
      if (f_mask[i] != 32'd0 && f_idx[i] <= nvec) begin
        nhit++;
        if (first == 0 || f_idx[i] < first) begin first = f_idx[i]; first_mask = f_mask[i]; end
      end
    rst_fail = (rst_net_val != 32'd0);
    exp_fidx = 16'd0; exp_fg = 32'd0; exp_fn = 32'd0;
    if (rst_fail) exp_fn = rst_net_val;
    else if (first != 0) begin
      exp_fidx = 16'(first); exp_fg = vseq[first]; exp_fn = vseq[first] ^ first_mask;
    end
    if (STOP && rst_fail) begin
      applied = 0; exp_mm = 1; lat = R; exp_pulse.push_back(R);
    end else if (STOP && first != 0) begin
      applied = first; exp_mm = 1; lat = R + 1 + first * (1 + S); exp_pulse.push_back(lat);
    end else begin
      applied = nvec; exp_mm = int'(rst_fail) + nhit; lat = R + 1 + nvec * (1 + S);
      if (rst_fail) exp_pulse.push_back(R);
      for (int i = 0; i < 4; i++)
        if (f_mask[i] != 32'd0 && f_idx[i] <= nvec) exp_pulse.push_back(R + 1 + f_idx[i] * (1 + S));
    end
    exp_stim = (applied == 0) ? 32'd0 : vseq[applied];

    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    n = 0; k = 0; prev = 32'd0; seq_bad = 0; rst_hi = 0; timed_out = 1'b1;
    while (n <= lat + 20) begin
      if (o_dut_rst && o_busy) rst_hi++;
      if (o_err) got_pulse.push_back(n);
      if (o_stim != prev) begin
        k++;
        if (k > applied || o_stim != vseq[k] || n != R + 2 + (k - 1) * (1 + S)) seq_bad++;
        prev = o_stim;
      end
      if (o_done) begin timed_out = 1'b0; break; end
      drive_start(n == 40 && o_busy);  // start while busy must be ignored
      @(negedge clk);
      n++;
    end
    drive_start(1'b0);
    pulse_bad = 0;
    foreach (got_pulse[i]) begin
      found = 1'b0;
      foreach (exp_pulse[j]) if (exp_pulse[j] == got_pulse[i]) found = 1'b1;
      if (!found) pulse_bad++;
    end
    check({tag, "_timeout"},   32'(timed_out), 32'd0);
    check({tag, "_latency"},   n, lat);
    check({tag, "_rst_cyc"},   rst_hi, R);
    check({tag, "_stim_seq"},  seq_bad, 0);
    check({tag, "_stim_chg"},  k, applied);
    check({tag, "_pulse_cnt"}, got_pulse.size(), exp_pulse.size());
    check({tag, "_pulse_pos"}, pulse_bad, 0);
    check({tag, "_done"},      32'(o_done), 32'd1);
    check({tag, "_busy"},      32'(o_busy), 32'd0);
    check({tag, "_dut_rst"},   32'(o_dut_rst), 32'd0);
    check({tag, "_pass"},      32'(o_pass), 32'(exp_mm == 0));
    check({tag, "_mm_cnt"},    32'(o_mm), exp_mm);
    check({tag, "_vec_cnt"},   32'(o_vc), applied);
    check({tag, "_fail_idx"},  32'(o_fi), 32'(exp_fidx));
    check({tag, "_fail_gold"}, o_fg, exp_fg);
    check({tag, "_fail_net"},  o_fn, exp_fn);
    check({tag, "_stim_end"},  o_stim, exp_stim);
  endtask

  task automatic abort_at(input int at_vec);
    int t;
    sel = 1'b0; t = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (a_vc != 16'(at_vec) && t < 5000) begin @(negedge clk); t++; end
    check("abort_reach", 32'(a_vc), at_vec);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",    32'(a_busy), 32'd0);
    check("abort_done",    32'(a_done), 32'd0);
    check("abort_vec_cnt", 32'(a_vc), 32'd0);
    check("abort_mm_cnt",  32'(a_mm), 32'd0);
    check("abort_dut_rst", 32'(a_dut_rst), 32'd1);
    check("abort_stim",    a_stim, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    vseq[0] = 32'd0;
    vseq[1] = SEED;
    for (int i = 2; i <= NA; i++) vseq[i] = lfsr_step(vseq[i-1]);
    clear_faults();
    sel = 1'b0; rst = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dut_rst", 32'(a_dut_rst), 32'd1);
    check("rst_stim",    a_stim, 32'd0);
    check("rst_busy",    32'(a_busy), 32'd0);
    check("rst_done",    32'(a_done), 32'd0);
    check("rst_pass",    32'(a_pass), 32'd0);
    check("rst_err",     32'(a_err), 32'd0);
    check("rst_fail",    {16'(a_mm | a_vc | a_fi), 16'd0} | a_fg | a_fn, 32'd0);
    check("rst_b_busy",  32'(b_busy), 32'd0);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    check("idle_busy",    32'(a_busy), 32'd0);
    check("idle_dut_rst", 32'(a_dut_rst), 32'd1);

    clear_faults();
    run_check("clean", 1'b0);

    clear_faults();
    set_fault(0, 7, 32'h20);
    run_check("bit5_v7", 1'b0);

    clear_faults();
    set_fault(0, 3, 32'h8000_0001);
    run_check("v3", 1'b0);

    random_faults(2, 1'b0);
    rst_net_val = 32'h1;
    run_check("rst_fail", 1'b0);

    clear_faults();
    abort_at(500);
    run_check("after_abort", 1'b0);

    for (int r = 0; r < 2; r++) begin
      random_faults($urandom_range(4, 1), $urandom_range(3, 0) == 0);
      run_check($sformatf("rand%0d", r), 1'b0);
    end

    clear_faults();
    run_check("nv0_clean", 1'b1);
    rst_net_val = 32'h1;
    run_check("nv0_rstfail", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
